// File: rtl/ber_checker_if.sv
// rtl/ber_checker_if.sv - PRBS7 BER checker control, data and status interface
interface ber_checker_if #(
    parameter int EBW = 24,
    parameter int BBW = 32
);
    logic           CLR;
    logic           DVALID;
    logic           DIN;
    logic           LOCKED;
    logic           LOL;
    logic [EBW-1:0] ERR_CNT;
    logic [BBW-1:0] BIT_CNT;

    modport master (output CLR, DVALID, DIN, input LOCKED, LOL, ERR_CNT, BIT_CNT);
    modport slave  (input CLR, DVALID, DIN, output LOCKED, LOL, ERR_CNT, BIT_CNT);
endinterface

// File: rtl/ber_checker.sv
// rtl/ber_checker.sv - self-synchronising PRBS7 bit error rate checker
module ber_checker #(
    parameter int EBW      = 24,
    parameter int BBW      = 32,
    parameter int LOCK_CNT = 32,
    parameter int WIN      = 64,
    parameter int ERR_LIM  = 8
) (
    input  logic          CLK,
    input  logic          RSTX,
    ber_checker_if.slave  io_link
);

    typedef enum logic {
        SYNC = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam logic [7:0] C_LOCK_CNT = 8'(LOCK_CNT);
    localparam logic [7:0] C_WIN_LAST = 8'(WIN - 1);
    localparam logic [7:0] C_ERR_LIM  = 8'(ERR_LIM);

    state_t         r_state;
    logic [6:0]     r_sr;
    logic [2:0]     r_fill;
    logic [7:0]     r_match;
    logic [7:0]     r_win;
    logic [7:0]     r_werr;
    logic           r_lol;
    logic [EBW-1:0] r_err_cnt;
    logic [BBW-1:0] r_bit_cnt;

    state_t         w_state_nxt;
    logic [6:0]     w_sr_nxt;
    logic [2:0]     w_fill_nxt;
    logic [7:0]     w_match_nxt;
    logic [7:0]     w_win_nxt;
    logic [7:0]     w_werr_nxt;
    logic           w_lol_nxt;
    logic [EBW-1:0] w_err_cnt_nxt;
    logic [BBW-1:0] w_bit_cnt_nxt;

    logic           w_pred;
    logic           w_err;
    logic [7:0]     w_werr_inc;

    // x^7+x^6+1: the next bit is the XOR of the two oldest history taps
    assign w_pred     = r_sr[6] ^ r_sr[5];
    assign w_err      = (io_link.DIN != w_pred);
    assign w_werr_inc = r_werr + {7'd0, w_err};

    // Next-state and counter update; CLR overrides everything, idle cycles hold state
    always_comb begin
        w_state_nxt   = r_state;
        w_sr_nxt      = r_sr;
        w_fill_nxt    = r_fill;
        w_match_nxt   = r_match;
        w_win_nxt     = r_win;
        w_werr_nxt    = r_werr;
        w_lol_nxt     = r_lol;
        w_err_cnt_nxt = r_err_cnt;
        w_bit_cnt_nxt = r_bit_cnt;

        if (io_link.CLR) begin
            w_state_nxt   = SYNC;
            w_sr_nxt      = 7'h00;
            w_fill_nxt    = 3'd0;
            w_match_nxt   = 8'd0;
            w_win_nxt     = 8'd0;
            w_werr_nxt    = 8'd0;
            w_lol_nxt     = 1'b0;
            w_err_cnt_nxt = '0;
            w_bit_cnt_nxt = '0;
        end else if (io_link.DVALID) begin
            case (r_state)
                SYNC: begin
                    // Learn the stream: received bits feed the history
                    w_sr_nxt = {r_sr[5:0], io_link.DIN};
                    if (r_fill != 3'd7) begin
                        w_fill_nxt = r_fill + 3'd1;
                    end else if (!w_err) begin
                        w_match_nxt = r_match + 8'd1;
                    end else begin
                        w_match_nxt = 8'd0;
                    end
                    if (w_match_nxt == C_LOCK_CNT) begin
                        w_state_nxt = LOCK;
                    end
                end
                LOCK: begin
                    // Free-running reference so a single flipped bit is one error, not three
                    w_sr_nxt = {r_sr[5:0], w_pred};
                    if (r_bit_cnt != '1) begin
                        w_bit_cnt_nxt = r_bit_cnt + BBW'(1);
                    end
                    if (w_err && (r_err_cnt != '1)) begin
                        w_err_cnt_nxt = r_err_cnt + EBW'(1);
                    end
                    if (r_win == C_WIN_LAST) begin
                        w_win_nxt  = 8'd0;
                        w_werr_nxt = 8'd0;
                    end else begin
                        w_win_nxt  = r_win + 8'd1;
                        w_werr_nxt = w_werr_inc;
                    end
                    if (w_werr_inc == C_ERR_LIM) begin
                        w_state_nxt = SYNC;
                        w_lol_nxt   = 1'b1;
                        w_fill_nxt  = 3'd0;
                        w_match_nxt = 8'd0;
                        w_win_nxt   = 8'd0;
                        w_werr_nxt  = 8'd0;
                    end
                end
                default: w_state_nxt = SYNC;
            endcase
        end
    end

    // State and counter registers, cleared asynchronously by RSTX
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            r_state   <= SYNC;
            r_sr      <= 7'h00;
            r_fill    <= 3'd0;
            r_match   <= 8'd0;
            r_win     <= 8'd0;
            r_werr    <= 8'd0;
            r_lol     <= 1'b0;
            r_err_cnt <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sr      <= w_sr_nxt;
            r_fill    <= w_fill_nxt;
            r_match   <= w_match_nxt;
            r_win     <= w_win_nxt;
            r_werr    <= w_werr_nxt;
            r_lol     <= w_lol_nxt;
            r_err_cnt <= w_err_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
        end
    end

    assign io_link.LOCKED  = (r_state == LOCK);
    assign io_link.LOL     = r_lol;
    assign io_link.ERR_CNT = r_err_cnt;
    assign io_link.BIT_CNT = r_bit_cnt;

endmodule

// File: tb/tb_ber_checker.sv
// tb/tb_ber_checker.sv - randomized self-checking bench for ber_checker
module tb_ber_checker;

    localparam int LOCK_CNT = 32;
    localparam int WIN      = 64;
    localparam int ERR_LIM  = 8;

    logic CLK  = 1'b0;
    logic RSTX = 1'b0;

    always #5 CLK = ~CLK;

    ber_checker_if #(.EBW(24), .BBW(32)) bus  ();
    ber_checker_if #(.EBW(4),  .BBW(32)) bus4 ();

    assign bus4.CLR    = bus.CLR;
    assign bus4.DVALID = bus.DVALID;
    assign bus4.DIN    = bus.DIN;

    ber_checker #(.EBW(24), .BBW(32), .LOCK_CNT(LOCK_CNT), .WIN(WIN), .ERR_LIM(ERR_LIM)) dut (
        .CLK     (CLK),
        .RSTX    (RSTX),
        .io_link (bus)
    );

    ber_checker #(.EBW(4), .BBW(32), .LOCK_CNT(LOCK_CNT), .WIN(WIN), .ERR_LIM(ERR_LIM)) dut4 (
        .CLK     (CLK),
        .RSTX    (RSTX),
        .io_link (bus4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit     m_locked;
    bit     m_lol;
    longint m_errs;
    longint m_bits;
    int     m_run;
    int     m_nlock;
    int     m_werr;
    bit     q_hist[$];
    bit     q_ref[$];

    logic [6:0]  tx_s;
    logic [57:0] exp24, act24;
    logic [37:0] exp4, act4;

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit tx_next();
        bit b;
        b    = tx_s[6] ^ tx_s[5];
        tx_s = {tx_s[5:0], b};
        return b;
    endfunction

    task automatic model_clear();
        m_locked = 1'b0; m_lol = 1'b0; m_errs = 0; m_bits = 0;
        m_run = 0; m_nlock = 0; m_werr = 0;
        q_hist.delete(); q_ref.delete();
    endtask

    task automatic model_step(input bit clr, input bit dv, input bit din);
        bit p;
        if (clr) begin
            model_clear();
        end else if (dv) begin
            if (!m_locked) begin
                if (q_hist.size() == 7) begin
                    p = q_hist[0] ^ q_hist[1];
                    if (din == p) m_run++;
                    else m_run = 0;
                end
                q_hist.push_back(din);
                if (q_hist.size() > 7) void'(q_hist.pop_front());
                if (m_run == LOCK_CNT) begin
                    m_locked = 1'b1; q_ref = q_hist; m_nlock = 0; m_werr = 0; m_run = 0;
                end
            end else begin
                p = q_ref[0] ^ q_ref[1];
                q_ref.push_back(p);
                void'(q_ref.pop_front());
                m_bits++;
                m_nlock++;
                if (din != p) begin m_errs++; m_werr++; end
                if (m_werr >= ERR_LIM) begin
                    m_locked = 1'b0; m_lol = 1'b1; q_hist.delete(); m_run = 0; m_werr = 0;
                end else if ((m_nlock % WIN) == 0) begin
                    m_werr = 0;
                end
            end
        end
    endtask

    task automatic cyc(input bit clr, input bit dv, input bit din);
        bus.CLR = clr; bus.DVALID = dv; bus.DIN = din;
        @(posedge CLK);
        model_step(clr, dv, din);
        #1;
        exp24 = {m_locked, m_lol, 24'(sat(m_errs, 24)), 32'(sat(m_bits, 32))};
        act24 = {bus.LOCKED, bus.LOL, bus.ERR_CNT, bus.BIT_CNT};
        exp4  = {m_locked, m_lol, 4'(sat(m_errs, 4)), 32'(sat(m_bits, 32))};
        act4  = {bus4.LOCKED, bus4.LOL, bus4.ERR_CNT, bus4.BIT_CNT};
    endtask

    task automatic send(input bit flip);
        cyc(1'b0, 1'b1, tx_next() ^ flip);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic do_clr(input int n);
        repeat (n) cyc(1'b1, 1'b1, tx_next());
    endtask

    task automatic test_reset();
        RSTX = 1'b0; bus.CLR = 1'b0; bus.DVALID = 1'b1; bus.DIN = 1'b1;
        model_clear();
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++; if (bus.LOCKED !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %0b want 0", bus.LOCKED); end
        n_cmp++; if (bus.LOL !== 1'b0) begin n_bad++; $display("FAIL reset_lol: got %0b want 0", bus.LOL); end
        n_cmp++; if (bus.ERR_CNT !== 24'd0) begin n_bad++; $display("FAIL reset_err: got %0d want 0", bus.ERR_CNT); end
        n_cmp++; if (bus.BIT_CNT !== 32'd0) begin n_bad++; $display("FAIL reset_bits: got %0d want 0", bus.BIT_CNT); end
        n_cmp++; if (bus4.ERR_CNT !== 4'd0) begin n_bad++; $display("FAIL reset_err4: got %0d want 0", bus4.ERR_CNT); end
        @(negedge CLK);
        RSTX = 1'b1;
    endtask

    task automatic test_clean_lock();
        tx_s = 7'h7F;
        for (int i = 1; i <= 39; i++) begin
            send(1'b0);
            if (i == 38) begin
                n_cmp++; if (bus.LOCKED !== 1'b0) begin n_bad++; $display("FAIL lock_early: got %0b want 0 at bit 38", bus.LOCKED); end
            end
        end
        n_cmp++; if (bus.LOCKED !== 1'b1) begin n_bad++; $display("FAIL lock_rise: got %0b want 1 at bit 39", bus.LOCKED); end
        repeat (1000) send(1'b0);
        n_cmp++; if (bus.BIT_CNT !== 32'd1000) begin n_bad++; $display("FAIL clean_bits: got %0d want 1000", bus.BIT_CNT); end
        n_cmp++; if (bus.ERR_CNT !== 24'd0) begin n_bad++; $display("FAIL clean_err: got %0d want 0", bus.ERR_CNT); end
        n_cmp++; if (bus.LOL !== 1'b0) begin n_bad++; $display("FAIL clean_lol: got %0b want 0", bus.LOL); end
        n_cmp++; if (act24 !== exp24) begin n_bad++; $display("FAIL clean_model: got %h want %h", act24, exp24); end
    endtask

    task automatic test_single_errors();
        int gap;
        for (int k = 1; k <= 10; k++) begin
            gap = $urandom_range(80, 120);
            repeat (gap - 1) send(1'b0);
            n_cmp++; if (bus.ERR_CNT !== 24'(k - 1)) begin n_bad++; $display("FAIL single_pre%0d: got %0d want %0d", k, bus.ERR_CNT, k - 1); end
            send(1'b1);
            n_cmp++; if (bus.ERR_CNT !== 24'(k)) begin n_bad++; $display("FAIL single_post%0d: got %0d want %0d", k, bus.ERR_CNT, k); end
            n_cmp++; if (bus.LOCKED !== 1'b1) begin n_bad++; $display("FAIL single_locked%0d: got %0b want 1", k, bus.LOCKED); end
        end
        send(1'b0);
        n_cmp++; if (bus.LOL !== 1'b0) begin n_bad++; $display("FAIL single_lol: got %0b want 0", bus.LOL); end
        n_cmp++; if (act24 !== exp24) begin n_bad++; $display("FAIL single_model: got %h want %h", act24, exp24); end
    endtask

    task automatic test_burst_lol();
        do_clr(1);
        repeat (49) send(1'b0);
        for (int i = 1; i <= 8; i++) begin
            send(1'b1);
            if (i == 7) begin
                n_cmp++; if (bus.LOCKED !== 1'b1) begin n_bad++; $display("FAIL burst_hold: got %0b want 1 after 7 errors", bus.LOCKED); end
            end
        end
        n_cmp++; if (bus.LOCKED !== 1'b0) begin n_bad++; $display("FAIL burst_unlock: got %0b want 0", bus.LOCKED); end
        n_cmp++; if (bus.LOL !== 1'b1) begin n_bad++; $display("FAIL burst_lol: got %0b want 1", bus.LOL); end
        n_cmp++; if (bus.ERR_CNT !== 24'd8) begin n_bad++; $display("FAIL burst_err: got %0d want 8", bus.ERR_CNT); end
        n_cmp++; if (bus.BIT_CNT !== 32'd18) begin n_bad++; $display("FAIL burst_bits: got %0d want 18", bus.BIT_CNT); end
        repeat (20) send(1'b0);
        n_cmp++; if (bus.BIT_CNT !== 32'd18) begin n_bad++; $display("FAIL burst_freeze: got %0d want 18", bus.BIT_CNT); end
        repeat (18) send(1'b0);
        n_cmp++; if (bus.LOCKED !== 1'b0) begin n_bad++; $display("FAIL relock_early: got %0b want 0 at bit 38", bus.LOCKED); end
        send(1'b0);
        n_cmp++; if (bus.LOCKED !== 1'b1) begin n_bad++; $display("FAIL relock: got %0b want 1 at bit 39", bus.LOCKED); end
        n_cmp++; if (bus.LOL !== 1'b1) begin n_bad++; $display("FAIL relock_lol: got %0b want 1", bus.LOL); end
        n_cmp++; if (act24 !== exp24) begin n_bad++; $display("FAIL burst_model: got %h want %h", act24, exp24); end
    endtask

    task automatic test_dvalid_toggle();
        do_clr(1);
        for (int v = 1; v <= 39; v++) begin
            send(1'b0);
            if (v == 38) begin
                n_cmp++; if (bus.LOCKED !== 1'b0) begin n_bad++; $display("FAIL toggle_early: got %0b want 0", bus.LOCKED); end
            end
            if (v == 39) begin
                n_cmp++; if (bus.LOCKED !== 1'b1) begin n_bad++; $display("FAIL toggle_lock: got %0b want 1 after 39 valid bits", bus.LOCKED); end
            end
            idle();
        end
        for (int v = 0; v < 25; v++) begin
            send(1'b0);
            idle();
        end
        n_cmp++; if (bus.BIT_CNT !== 32'd25) begin n_bad++; $display("FAIL toggle_bits: got %0d want 25", bus.BIT_CNT); end
        n_cmp++; if (act24 !== exp24) begin n_bad++; $display("FAIL toggle_model: got %h want %h", act24, exp24); end
    endtask

    task automatic test_clr();
        do_clr(1);
        repeat (45) send(1'b0);
        for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(5, 9)) send(1'b0);
            send(1'b1);
        end
        n_cmp++; if (bus.ERR_CNT !== 24'd5) begin n_bad++; $display("FAIL clr_pre_err: got %0d want 5", bus.ERR_CNT); end
        n_cmp++; if (bus.LOCKED !== 1'b1) begin n_bad++; $display("FAIL clr_pre_lock: got %0b want 1", bus.LOCKED); end
        for (int c = 0; c < 15; c++) begin
            cyc(1'b1, 1'b1, tx_next() ^ 1'($urandom_range(0, 1)));
            n_cmp++;
            if ({bus.LOCKED, bus.LOL, bus.ERR_CNT, bus.BIT_CNT} !== 58'd0) begin
                n_bad++; $display("FAIL clr_hold%0d: got %h want 0", c, {bus.LOCKED, bus.LOL, bus.ERR_CNT, bus.BIT_CNT});
            end
        end
        repeat (38) send(1'b0);
        n_cmp++; if (bus.LOCKED !== 1'b0) begin n_bad++; $display("FAIL clr_relock_early: got %0b want 0", bus.LOCKED); end
        send(1'b0);
        n_cmp++; if (bus.LOCKED !== 1'b1) begin n_bad++; $display("FAIL clr_relock: got %0b want 1", bus.LOCKED); end
        n_cmp++; if (bus.BIT_CNT !== 32'd0) begin n_bad++; $display("FAIL clr_bits: got %0d want 0", bus.BIT_CNT); end
    endtask

    task automatic test_saturation();
        do_clr(1);
        repeat (39) send(1'b0);
        for (int k = 1; k <= 20; k++) begin
            repeat (99) send(1'b0);
            send(1'b1);
            if (k == 14) begin
                n_cmp++; if (bus4.ERR_CNT !== 4'd14) begin n_bad++; $display("FAIL sat_pre: got %0d want 14", bus4.ERR_CNT); end
            end
            if (k == 15 || k == 20) begin
                n_cmp++; if (bus4.ERR_CNT !== 4'd15) begin n_bad++; $display("FAIL sat_hold%0d: got %0d want 15", k, bus4.ERR_CNT); end
            end
        end
        n_cmp++; if (bus.ERR_CNT !== 24'd20) begin n_bad++; $display("FAIL sat_wide: got %0d want 20", bus.ERR_CNT); end
        n_cmp++; if (bus4.BIT_CNT !== 32'd2000) begin n_bad++; $display("FAIL sat_bits: got %0d want 2000", bus4.BIT_CNT); end
        n_cmp++; if (act4 !== exp4) begin n_bad++; $display("FAIL sat_model: got %h want %h", act4, exp4); end
    endtask

    task automatic test_async_reset();
        do_clr(1);
        repeat (45) send(1'b0);
        #2;
        RSTX = 1'b0;
        #1;
        model_clear();
        n_cmp++; if (bus.LOCKED !== 1'b0) begin n_bad++; $display("FAIL async_locked: got %0b want 0", bus.LOCKED); end
        n_cmp++; if (bus.BIT_CNT !== 32'd0) begin n_bad++; $display("FAIL async_bits: got %0d want 0", bus.BIT_CNT); end
        @(negedge CLK);
        RSTX = 1'b1;
    endtask

    task automatic test_random();
        int  burst;
        bit  flip;
        burst = 0;
        do_clr(1);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 1499) == 0) begin
                do_clr(1);
            end else if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                if (burst == 0 && $urandom_range(0, 699) == 0) burst = $urandom_range(4, 10);
                flip = (burst > 0) || ($urandom_range(0, 59) == 0);
                if (burst > 0) burst--;
                send(flip);
            end
            n_cmp++; if (act24 !== exp24) begin n_bad++; $display("FAIL rand24 c%0d: got %h want %h", c, act24, exp24); end
            n_cmp++; if (act4 !== exp4) begin n_bad++; $display("FAIL rand4 c%0d: got %h want %h", c, act4, exp4); end
        end
    endtask

    initial begin
        bus.CLR = 1'b0; bus.DVALID = 1'b0; bus.DIN = 1'b0;
        tx_s = 7'h7F;
        test_reset();
        test_clean_lock();
        test_single_errors();
        test_burst_lol();
        test_dvalid_toggle();
        test_clr();
        test_saturation();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
